// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
package arb_pkg;

  localparam int unsigned NDefault       = 4;
  localparam int unsigned MaxHoldDefault = 8;

  typedef enum logic {StIdle, StGrant} state_e;

  // Index width, kept at least one bit wide.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~excl) searching upward from ptr.
module rr_pick import arb_pkg::*; #(
  parameter int unsigned N = NDefault,
  parameter int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic [N-1:0] excl_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] masked;
  logic [N-1:0] rot;
  int unsigned  src;
  int unsigned  sel;

  always_comb begin
    masked = req_i & ~excl_i;
    rot    = '0;
    src    = 0;
    sel    = 0;
    // Rotate so that bit 0 of rot is the requester at ptr.
    for (int unsigned i = 0; i < N; i++) begin
      src = i + 32'(ptr_i);
      if (src >= N) src = src - N;
      rot[i] = masked[src[W-1:0]];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sel = 32'(i);
    end
    src = sel + 32'(ptr_i);
    if (src >= N) src = src - N;
    found_o = |rot;
    idx_o   = src[W-1:0];
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with grant hold; optional forced rotation after MAX_HOLD cycles
// when built with RR_ARBITER_TIMEOUT_EN defined.
module rr_arbiter import arb_pkg::*; #(
  parameter int unsigned N        = NDefault,
  parameter int unsigned MAX_HOLD = MaxHoldDefault
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N-1:0]            i_req,
  output logic [N-1:0]            o_gnt,
  output logic [idx_width(N)-1:0] o_gnt_id,
  output logic                    o_busy,
  output logic                    o_preempt
);

  localparam int unsigned W = idx_width(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("rr_arbiter: N must be in 2..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD must be at least 2");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   gnt_id_q, gnt_id_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]   excl;
  logic           pick_found;
  logic [W-1:0]   pick_idx;
  logic           take;

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          preempt_q, preempt_d;
`endif

  // The current owner never competes against itself, on release or on timeout.
  always_comb begin
    excl = '0;
    if (state_q == StGrant) excl[gnt_id_q] = 1'b1;
  end

  rr_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .req_i  (i_req),
    .ptr_i  (ptr_q),
    .excl_i (excl),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    take     = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: take = pick_found;
      StGrant: begin
        if (!i_req[gnt_id_q]) begin
          take = pick_found;
          if (!pick_found) begin
            state_d  = StIdle;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
`ifdef RR_ARBITER_TIMEOUT_EN
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          // Saturate when nobody else wants the resource.
          take      = pick_found;
          preempt_d = pick_found;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: ;
    endcase
    if (take) begin
      state_d            = StGrant;
      gnt_d              = '0;
      gnt_d[pick_idx]    = 1'b1;
      gnt_id_d           = pick_idx;
      ptr_d              = (pick_idx == W'(N - 1)) ? '0 : pick_idx + 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
      cnt_d              = CW'(1);
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign o_preempt = preempt_q;
`else
  assign o_preempt = 1'b0;
`endif

  assign o_gnt    = gnt_q;
  assign o_gnt_id = gnt_id_q;
  assign o_busy   = (state_q == StGrant);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=8): vector table plus hold/timeout sequences.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int unsigned n_total;
  int unsigned n_pass;

  rr_arbiter #(
    .N(4),
    .MAX_HOLD(8)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .o_gnt    (gnt),
    .o_gnt_id (gnt_id),
    .o_busy   (busy),
    .o_preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change #1 after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;

    //            rst   req      gnt      id    busy
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1};
    vecs[5]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1};
    vecs[6]  = '{1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1};
    vecs[7]  = '{1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[12] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[13] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1};
    vecs[14] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[15] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[16] = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1};
    vecs[17] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[18] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0};
    vecs[19] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[20] = '{1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1};
    vecs[21] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};

    step();
    for (int i = 0; i < 22; i++) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      step();
      check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d id", i), 32'(gnt_id), 32'(vecs[i].id));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d preempt", i), 32'(preempt), 32'd0);
    end

`ifndef RR_ARBITER_TIMEOUT_EN
    // Hold: owner 2 keeps the grant indefinitely while requester 1 waits.
    do_reset();
    req = 4'b0100;
    step();
    check("hold first", 32'(gnt), 32'b0100);
    req = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("hold cyc%0d", i), 32'(gnt), 32'b0100);
    end
    req = 4'b0010;
    step();
    check("hold handoff gnt", 32'(gnt), 32'b0010);
    check("hold handoff id", 32'(gnt_id), 32'd1);
`else
    // Timeout: 0 and 1 alternate every MAX_HOLD cycles with a preempt pulse.
    do_reset();
    req = 4'b0011;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("to own0 cyc%0d", i), 32'(gnt), 32'b0001);
      check($sformatf("to own0 pre%0d", i), 32'(preempt), 32'd0);
    end
    step();
    check("to switch1 gnt", 32'(gnt), 32'b0010);
    check("to switch1 pre", 32'(preempt), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      step();
      check($sformatf("to own1 cyc%0d", i), 32'(gnt), 32'b0010);
      check($sformatf("to own1 pre%0d", i), 32'(preempt), 32'd0);
    end
    step();
    check("to switch0 gnt", 32'(gnt), 32'b0001);
    check("to switch0 pre", 32'(preempt), 32'd1);

    // Lone owner: counter saturates, no preemption.
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 30; i++) begin
      step();
      check($sformatf("lone gnt%0d", i), 32'(gnt), 32'b1000);
      check($sformatf("lone pre%0d", i), 32'(preempt), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
